// File: rtl/rca_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry add/subtract unit.
package rca_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEG_W = 8;

    function automatic int unsigned num_stages(input int unsigned width, input int unsigned seg_w);
        return (seg_w == 0) ? 0 : width / seg_w;
    endfunction

    function automatic bit widths_legal(input int unsigned width, input int unsigned seg_w);
        return (width != 0) && (seg_w != 0) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG_W-bit ripple-carry segment; one instance per pipeline stage.
module rca_seg #(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout
);

    logic [SEG_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(SEG_W); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SEG_W];

endmodule

// File: rtl/rca_pipe_addsub.sv
// Pipelined add/subtract: one SEG_W-bit ripple segment per stage, registered carries between
// stages, valid/ready at both ends with per-stage bubble-collapsing back-pressure.
module rca_pipe_addsub
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NSTAGE = num_stages(WIDTH, SEG_W);

    if (!widths_legal(WIDTH, SEG_W)) begin : g_bad_width
        $error("rca_pipe_addsub: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic [NSTAGE:0]   adv;
    logic [NSTAGE-1:0] v_w;
    logic [NSTAGE-1:0] c_w;
    logic [WIDTH-1:0]  res_w [NSTAGE];
    logic [WIDTH-1:0]  a_w   [NSTAGE];
    logic [WIDTH-1:0]  b_w   [NSTAGE];
    logic [WIDTH-1:0]  b_eff;

    assign b_eff = sub ? ~b : b;

    // A stage may load when it is empty or its successor is moving.
    always_comb begin
        adv         = '0;
        adv[NSTAGE] = out_ready;
        for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
            adv[k] = !v_w[k] || adv[k+1];
        end
    end

    assign in_ready  = adv[0] && rst;
    assign out_valid = v_w[NSTAGE-1];
    assign s         = res_w[NSTAGE-1];
    assign carry_out = c_w[NSTAGE-1];

    for (genvar k = 0; k < int'(NSTAGE); k++) begin : g_stage
        logic             v_in;
        logic             ci;
        logic [WIDTH-1:0] res_in;
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [SEG_W-1:0] sum;
        logic             co;
        logic             ld;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] res_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;

        if (k == 0) begin : g_first
            assign v_in   = in_valid;
            assign ci     = carry_in;
            assign res_in = '0;
            assign a_in   = a;
            assign b_in   = b_eff;
        end else begin : g_next
            assign v_in   = v_w[k-1];
            assign ci     = c_w[k-1];
            assign res_in = res_w[k-1];
            assign a_in   = a_w[k-1];
            assign b_in   = b_w[k-1];
        end

        rca_seg #(.SEG_W(SEG_W)) u_seg (
            .a    (a_in[k*SEG_W +: SEG_W]),
            .b    (b_in[k*SEG_W +: SEG_W]),
            .cin  (ci),
            .s    (sum),
            .cout (co)
        );

        assign ld = adv[k] && v_in;

        // Stage register: valid follows the handshake, payload only loads with a real beat.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
                a_q   <= '0;
                b_q   <= '0;
            end else begin
                if (adv[k]) begin
                    v_q <= v_in;
                end
                if (ld) begin
                    res_q                   <= res_in;
                    res_q[k*SEG_W +: SEG_W] <= sum;
                    c_q                     <= co;
                    a_q                     <= a_in;
                    b_q                     <= b_in;
                end
            end
        end

        assign v_w[k]   = v_q;
        assign c_w[k]   = c_q;
        assign res_w[k] = res_q;
        assign a_w[k]   = a_q;
        assign b_w[k]   = b_q;

        if (k == int'(NSTAGE) - 1) begin : g_last
            logic ovf_q;

            // Signed overflow resolves in the top segment, so it is registered alongside it.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ovf_q <= 1'b0;
                end else if (ld) begin
                    ovf_q <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[SEG_W-1] != a_in[WIDTH-1]);
                end
            end

            assign overflow = ovf_q;
        end
    end

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Randomised and directed bench for rca_pipe_addsub against an arithmetic reference model.
module tb_rca_pipe_addsub;

    localparam int WIDTH  = 32;
    localparam int SEG_W  = 8;
    localparam int NSTAGE = WIDTH / SEG_W;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        carry_out;
    logic        overflow;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   pops    = 0;
    int   last_lat = 0;
    logic last_acc = 1'b0;
    logic [31:0] last_s;
    logic        last_c;
    logic        last_o;
    exp_t exp_q[$];

    rca_pipe_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned sum for s/carry, wide signed sum for overflow.
    function automatic exp_t model(input logic [31:0] xa, input logic [31:0] xb,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [31:0] bp;
        logic [63:0] u;
        longint      sr;
        bp  = sb ? ~xb : xb;
        u   = 64'(xa) + 64'(bp) + 64'(ci);
        sr  = longint'($signed(xa)) + longint'($signed(bp)) + longint'(ci);
        e.s = u[31:0];
        e.c = u[32];
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.t = 0;
        return e;
    endfunction

    // One clock: called at a falling edge with inputs already set.
    task automatic cycle();
        exp_t e;
        #1;
        last_acc = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q[0];
                check("result", {30'b0, overflow, carry_out, s}, {30'b0, e.o, e.c, e.s});
                if (out_ready) begin
                    exp_q.delete(0);
                    last_s   = s;
                    last_c   = carry_out;
                    last_o   = overflow;
                    last_lat = cyc - e.t;
                    pops++;
                end
            end
        end
        if (in_valid && in_ready) begin
            e   = model(a, b, carry_in, sub);
            e.t = cyc;
            exp_q.push_back(e);
            last_acc = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic new_beat();
        a        = pick();
        b        = pick();
        carry_in = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // Single beat into an empty pipe; waits for its result and checks latency.
    task automatic send_one(input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tc, input logic ts);
        int n;
        int p0;
        a         = ta;
        b         = tb_v;
        carry_in  = tc;
        sub       = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n         = 0;
        last_acc  = 1'b0;
        while (!last_acc && n < 50) begin
            cycle();
            n++;
        end
        in_valid = 1'b0;
        if (!last_acc) check("accept_timeout", 64'(0), 64'(1));
        p0 = pops;
        n  = 0;
        while (pops == p0 && n < 50) begin
            cycle();
            n++;
        end
        if (pops == p0) check("result_timeout", 64'(0), 64'(1));
        else            check("latency", 64'(last_lat), 64'(NSTAGE));
    endtask

    initial begin
        int sent;
        int acc_win;
        int n;

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_s",         64'(s),         64'(0));
        check("rst_carry_out", 64'(carry_out), 64'(0));
        check("rst_overflow",  64'(overflow),  64'(0));
        check("rst_in_ready",  64'(in_ready),  64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'(1));

        send_one(32'h0000_00FF, 32'h1, 1'b0, 1'b0);
        check("t1_result", {30'b0, last_o, last_c, last_s}, {30'b0, 1'b0, 1'b0, 32'h0000_0100});
        send_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        check("t2_result", {30'b0, last_o, last_c, last_s}, {30'b0, 1'b0, 1'b1, 32'h0000_0000});
        send_one(32'h0000_003C, 32'h4, 1'b1, 1'b1);
        check("t3a_result", {31'b0, last_c, last_s}, {31'b0, 1'b1, 32'h0000_0038});
        send_one(32'h0000_0004, 32'h3C, 1'b1, 1'b1);
        check("t3b_result", {31'b0, last_c, last_s}, {31'b0, 1'b0, 32'hFFFF_FFC8});
        send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        check("t4a_result", {31'b0, last_o, last_s}, {31'b0, 1'b1, 32'h8000_0000});
        send_one(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        check("t4b_overflow", 64'(last_o), 64'(1));

        // Back-pressure: consumer stalled for 10 cycles while the producer streams.
        out_ready = 1'b0;
        sent = 0; acc_win = 0;
        new_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (last_acc) begin
                sent++; acc_win++;
                if (sent < 20) new_beat(); else in_valid = 1'b0;
            end
        end
        check("bp_accepts", 64'(acc_win), 64'(NSTAGE));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        n = 0;
        while (sent < 20 && n < 200) begin
            cycle();
            if (last_acc) begin
                sent++;
                if (sent < 20) new_beat(); else in_valid = 1'b0;
            end
            n++;
        end
        check("bp_sent", 64'(sent), 64'(20));
        drain();

        // Random valid/ready traffic.
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (last_acc || !in_valid) begin
                in_valid = ($urandom_range(0, 2) != 0);
                new_beat();
            end
            cycle();
        end
        drain();

        // Reset with beats in flight.
        out_ready = 1'b0;
        sent = 0; n = 0;
        new_beat();
        in_valid = 1'b1;
        while (sent < 3 && n < 20) begin
            cycle();
            if (last_acc) begin
                sent++;
                if (sent < 3) new_beat(); else in_valid = 1'b0;
            end
            n++;
        end
        cycle();
        cycle();
        check("pre_reset_out_valid", 64'(out_valid), 64'(1));
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_s",         64'(s),         64'(0));
        check("midrst_in_ready",  64'(in_ready),  64'(0));
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("post_reset_idle", 64'(out_valid), 64'(0));
        end
        send_one(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        check("post_reset_result", 64'(last_s), 64'(32'h2345_6789));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
